mult_share_ctrl: RTL and testbench
==================================

Name: mult_share_ctrl

Overview:
- Sequencer and arbiter that shares one signed Booth multiplier (8x8 -> 16) among NUM_REQ requesters.
- Accepts operand requests over valid/ready, grants one at a time round-robin, and starts the multiplier.
- Waits for multiplier done, then returns the product tagged with the requester ID, then pulses a clear so the multiplier can accept the next job.
- Sits between client blocks and the multiplier datapath/FSM pair.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- OP_W, 8: operand width; product is 2*OP_W.
- ID_W, 2: width of requester index; must be >= clog2(NUM_REQ).
- TIMEOUT_CYCLES, 64: watchdog limit, used only with MULT_SHARE_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot grant/accept
- req_a  in  NUM_REQ*OP_W  multiplicands, slice i belongs to requester i
- req_b  in  NUM_REQ*OP_W  multipliers, slice i
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  ID_W  index of the served requester
- rsp_product  out  2*OP_W  signed product
- rsp_err  out  1  timeout flag (constant 0 without the macro)
- mult_valid  out  1  start level to the multiplier
- mult_m  out  OP_W  multiplicand to the multiplier
- mult_q  out  OP_W  multiplier operand
- mult_done  in  1  multiplier done (sticky until cleared)
- mult_product  in  2*OP_W  multiplier result {A,Q}
- mult_clear  out  1  one-cycle synchronous clear to the multiplier

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - req_ready = one-hot round-robin winner among req_valid. This is combinational, gated by state==IDLE and mult_done==0.
  - The handshake completes in the same cycle. Latch a/b/id, set pointer = winner, go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - mult_valid=1; mult_m/mult_q driven from latched registers, stable throughout.
  - When mult_done=1: latch mult_product, go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/rsp_product held stable until rsp_ready=1.
  - On that handshake go to CLEAR.
- CLEAR: mult_clear=1 for exactly one cycle, mult_valid=0, then IDLE.
- Throughput and latency:
  - At most one job in flight.
  - Accept-to-rsp_valid = multiplier latency + 1 cycle.
  - Minimum request-to-request spacing = multiplier latency + 3 cycles.
- Round-robin fairness: search order is pointer+1 ... pointer (wraps at NUM_REQ-1 -> 0). A requester that keeps req_valid high waits at most NUM_REQ-1 grants.
- Boundary conditions:
  - req_valid dropping in IDLE before grant: no effect.
  - req_valid asserted during BUSY/RESP/CLEAR: ignored until IDLE; req_ready stays 0.
  - rsp_ready high outside RESP: ignored.
  - mult_done already high in IDLE (stale): no grant; go to CLEAR first.
  - Async reset mid-job: drops the job with no response; rr pointer is reinitialised.
- Arithmetic: operands passed unmodified (two's complement). The product is the multiplier's 2*OP_W result, unaltered.

Optional Feature:
- Macro: MULT_SHARE_TIMEOUT_EN.
- With the macro:
  - A counter runs in BUSY.
  - If mult_done has not arrived after TIMEOUT_CYCLES cycles, go to RESP with rsp_err=1 and rsp_product=0.
  - CLEAR follows as normal.
- Without the macro: no counter; rsp_err tied 0; BUSY waits indefinitely.

Decomposition:
- Package mult_share_pkg: state enum (IDLE, BUSY, RESP, CLEAR, 2-bit), OP_W default constant, product-width helper.
- Sub-module rr_arbiter: pointer, request vector in, one-hot grant plus encoded index out. Purely combinational search; pointer update lives in the parent.

Test Plan:
- Single request: req0 a=3, b=5 -> req_ready[0] pulses once, mult_valid until done, then rsp_valid with id=0, product=16'h000F, then one mult_clear pulse.
- Signed: req2 a=8'hFC (-4), b=8'h07 -> product=16'hFFE4 (-28), id=2.
- Contention: all four req_valid held high with distinct operands -> grant order 0,1,2,3,0; each product matches its own operands.
- Backpressure: rsp_ready low for 10 cycles in RESP -> rsp_valid, id and product stable; no req_ready and no mult_clear until accepted.
- Async reset asserted during BUSY -> all outputs 0 immediately and no response. After release, req1 is served correctly with priority starting at 0.
- With MULT_SHARE_TIMEOUT_EN, TIMEOUT_CYCLES=64, mult_done held 0 -> rsp_valid at cycle 64 of BUSY with rsp_err=1, product=0, followed by mult_clear.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared types and constants for the multiplier-sharing controller.
// The sequencer state, the default operand width and the product-width helper live here.
package mult_share_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_RESP  = 2'd2,
      ST_CLEAR = 2'd3
   } state_e;

   localparam int OP_W_DEF = 8;

   function automatic int prod_w(input int op_w);
      return 2 * op_w;
   endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin search: the first requester after ptr (wrapping) wins.
// Produces a one-hot grant and its encoded index; the pointer register lives in the parent.
module rr_arbiter
   import mult_share_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [ID_W-1:0]    ptr,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_idx
);

   localparam logic [NUM_REQ-1:0] ONE_V = {{(NUM_REQ-1){1'b0}}, 1'b1};
   localparam logic [ID_W:0]      N_V   = (ID_W+1)'(NUM_REQ);

   logic [ID_W:0] pos_s;
   logic          hit_s;
   logic          found_s;

   // Walk ptr+1 .. ptr+NUM_REQ modulo NUM_REQ and keep the first hit.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found_s = 1'b0;
      pos_s   = '0;
      hit_s   = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         pos_s   = {1'b0, ptr} + (ID_W+1)'(k);
         pos_s   = (pos_s >= N_V) ? (pos_s - N_V) : pos_s;
         hit_s   = !found_s && ((req & (ONE_V << pos_s)) != '0);
         gnt     = hit_s ? (ONE_V << pos_s) : gnt;
         gnt_idx = hit_s ? pos_s[ID_W-1:0] : gnt_idx;
         found_s = found_s | hit_s;
      end
   end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one signed multiplier among NUM_REQ requesters: grant, start, wait done, respond, clear.
// Optional watchdog on the multiplier is enabled with MULT_SHARE_TIMEOUT_EN.
module mult_share_ctrl
   import mult_share_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int OP_W           = OP_W_DEF,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*OP_W-1:0] req_a,
   input  logic [NUM_REQ*OP_W-1:0] req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [prod_w(OP_W)-1:0] rsp_product,
   output logic                    rsp_err,
   output logic                    mult_valid,
   output logic [OP_W-1:0]         mult_m,
   output logic [OP_W-1:0]         mult_q,
   input  logic                    mult_done,
   input  logic [prod_w(OP_W)-1:0] mult_product,
   output logic                    mult_clear
);

   localparam int PW = prod_w(OP_W);

   state_e            state_q, state_d;
   logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
   logic [ID_W-1:0]   id_q, id_d, ptr_q, ptr_d;
   logic [PW-1:0]     prod_q, prod_d;
   logic              mult_valid_q, mult_valid_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              mult_clear_q, mult_clear_d;
   logic [NUM_REQ-1:0] gnt_s;
   logic [ID_W-1:0]   gnt_idx_s;
   logic [OP_W-1:0]   a_sel_s, b_sel_s;
   logic              accept_s;

`ifdef MULT_SHARE_TIMEOUT_EN
   localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .ptr     (ptr_q),
      .req     (req_valid),
      .gnt     (gnt_s),
      .gnt_idx (gnt_idx_s)
   );

   // A stale done must be cleared before any new job is accepted.
   assign req_ready = (state_q == ST_IDLE && !mult_done) ? gnt_s : '0;
   assign accept_s  = |req_ready;

   // Pick the winner's operand slices.
   always_comb begin
      a_sel_s = '0;
      b_sel_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         a_sel_s = a_sel_s | (req_a[i*OP_W +: OP_W] & {OP_W{gnt_s[i]}});
         b_sel_s = b_sel_s | (req_b[i*OP_W +: OP_W] & {OP_W{gnt_s[i]}});
      end
   end

   // Sequencer next state and datapath latches.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      prod_d  = prod_q;
`ifdef MULT_SHARE_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (mult_done) begin
               state_d = ST_CLEAR;
            end else if (accept_s) begin
               a_d     = a_sel_s;
               b_d     = b_sel_s;
               id_d    = gnt_idx_s;
               ptr_d   = gnt_idx_s;
               state_d = ST_BUSY;
`ifdef MULT_SHARE_TIMEOUT_EN
               cnt_d   = '0;
               err_d   = 1'b0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (mult_done) begin
               prod_d  = mult_product;
               state_d = ST_RESP;
            end
`ifdef MULT_SHARE_TIMEOUT_EN
            else if (cnt_q == TMO_LAST) begin
               prod_d  = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
`else
            else begin
               state_d = ST_BUSY;
            end
`endif
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_CLEAR;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_CLEAR: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      mult_valid_d = (state_d == ST_BUSY);
      rsp_valid_d  = (state_d == ST_RESP);
      mult_clear_d = (state_d == ST_CLEAR);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= '0;
         ptr_q        <= ID_W'(NUM_REQ - 1);
         prod_q       <= '0;
         mult_valid_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
         mult_clear_q <= 1'b0;
`ifdef MULT_SHARE_TIMEOUT_EN
         cnt_q        <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         id_q         <= id_d;
         ptr_q        <= ptr_d;
         prod_q       <= prod_d;
         mult_valid_q <= mult_valid_d;
         rsp_valid_q  <= rsp_valid_d;
         mult_clear_q <= mult_clear_d;
`ifdef MULT_SHARE_TIMEOUT_EN
         cnt_q        <= cnt_d;
         err_q        <= err_d;
`endif
      end
   end

   assign mult_valid  = mult_valid_q;
   assign mult_m      = a_q;
   assign mult_q      = b_q;
   assign mult_clear  = mult_clear_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = id_q;
   assign rsp_product = prod_q;

`ifdef MULT_SHARE_TIMEOUT_EN
   assign rsp_err = err_q;
`else
   logic unused_timeout_s;
   assign unused_timeout_s = ^TIMEOUT_CYCLES;
   assign rsp_err          = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl with a behavioural multiplier and round-robin reference.
// Define MULT_SHARE_TIMEOUT_EN to also exercise the watchdog path.
module tb_mult_share_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid, req_ready;
   logic [31:0] req_a, req_b;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_product, mult_product;
   logic        mult_valid, mult_done, mult_clear;
   logic [7:0]  mult_m, mult_q;

   mult_share_ctrl dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_product(rsp_product), .rsp_err(rsp_err),
      .mult_valid(mult_valid), .mult_m(mult_m), .mult_q(mult_q),
      .mult_done(mult_done), .mult_product(mult_product), .mult_clear(mult_clear)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Behavioural multiplier: sticky done after a random latency, cleared by mult_clear.
   logic       hang = 1'b0, inject_stale = 1'b0;
   logic       m_busy, m_done;
   logic [2:0] m_cnt;
   logic [7:0] m_a, m_b;
   logic [15:0] m_prod;
   assign mult_done    = m_done;
   assign mult_product = m_prod;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 3'd0; m_prod <= 16'd0;
         m_a <= 8'd0; m_b <= 8'd0;
      end else if (mult_clear) begin
         m_busy <= 1'b0; m_done <= 1'b0;
      end else if (inject_stale) begin
         m_done <= 1'b1; m_prod <= 16'h1234;
      end else if (m_busy) begin
         if (!hang) begin
            if (m_cnt == 3'd0) begin
               m_busy <= 1'b0; m_done <= 1'b1;
               m_prod <= 16'(int'($signed(m_a)) * int'($signed(m_b)));
            end else begin
               m_cnt <= m_cnt - 3'd1;
            end
         end
      end else if (mult_valid && !m_done) begin
         m_busy <= 1'b1; m_a <= mult_m; m_b <= mult_q;
         m_cnt  <= 3'($urandom_range(4, 0));
      end
   end

   // Reference model state.
   typedef struct { logic [1:0] id; logic [15:0] prod; logic err; } exp_t;
   exp_t sb_q[$];
   exp_t held;
   int   dut_grants[$];
   bit   in_flight = 1'b0, shown = 1'b0, exp_clear = 1'b0, mon_clear_n;
   int   last = 3, resp_cnt = 0, w;
   logic [3:0] acc_v = 4'd0, mon_rdy;
   logic [7:0] mon_a, mon_b;

   function automatic int rr_pick(input logic [3:0] v, input int from);
      for (int k = 1; k <= 4; k++) begin
         if (v[(from + k) % 4]) return (from + k) % 4;
      end
      return -1;
   endfunction

   // Monitor: predicts grants at issue time, checks responses and clear pulses.
   always @(negedge clk) begin
      if (reset) begin
         sb_q.delete(); in_flight = 1'b0; last = 3; exp_clear = 1'b0; shown = 1'b0; acc_v = 4'd0;
      end else begin
         acc_v = req_valid & req_ready;
         chk("mult_clear", {31'd0, mult_clear}, {31'd0, exp_clear});
         mon_clear_n = 1'b0;
         mon_rdy     = 4'd0;
         if (!in_flight && mult_done) begin
            in_flight   = 1'b1;
            mon_clear_n = 1'b1;
         end else if (!in_flight) begin
            w = rr_pick(req_valid, last);
            if (w >= 0) begin
               mon_rdy   = 4'b0001 << w;
               mon_a     = req_a[w*8 +: 8];
               mon_b     = req_b[w*8 +: 8];
               sb_q.push_back('{id: 2'(w),
                                prod: hang ? 16'd0 : 16'(int'($signed(mon_a)) * int'($signed(mon_b))),
                                err: hang});
               last      = w;
               in_flight = 1'b1;
            end
         end
         chk("req_ready", {28'd0, req_ready}, {28'd0, mon_rdy});
         for (int i = 0; i < 4; i++) if (req_ready[i]) dut_grants.push_back(i);
         if (mult_clear) in_flight = 1'b0;
         if (rsp_valid) begin
            if (!shown) begin
               if (sb_q.size() == 0) begin
                  chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
               end else begin
                  held = sb_q.pop_front();
                  chk("rsp_id", {30'd0, rsp_id}, {30'd0, held.id});
                  chk("rsp_product", {16'd0, rsp_product}, {16'd0, held.prod});
                  chk("rsp_err", {31'd0, rsp_err}, {31'd0, held.err});
               end
            end else begin
               chk("hold_id", {30'd0, rsp_id}, {30'd0, held.id});
               chk("hold_product", {16'd0, rsp_product}, {16'd0, held.prod});
            end
            if (rsp_ready) begin
               shown = 1'b0; resp_cnt++; mon_clear_n = 1'b1;
            end else begin
               shown = 1'b1;
            end
         end
         exp_clear = mon_clear_n;
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      req_a[i*8 +: 8] = a;
      req_b[i*8 +: 8] = b;
   endtask

   // Raise the masked requests and drop each one once it is accepted.
   task automatic serve(input logic [3:0] mask);
      logic [3:0] pending;
      int n;
      pending   = mask;
      req_valid = req_valid | mask;
      n = 0;
      while (pending != 4'd0 && n < 400) begin
         cycle();
         pending   = pending & ~acc_v;
         req_valid = req_valid & ~acc_v;
         n++;
      end
      chk("serve_timeout", {28'd0, pending}, 32'd0);
   endtask

   task automatic wait_quiet();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || in_flight) && n < 400) begin
         cycle();
         n++;
      end
      chk("quiet_timeout", {31'd0, n >= 400}, 32'd0);
      repeat (2) cycle();
   endtask

   initial begin
      int g, n, rc;
      int exp_ord[5] = '{0, 1, 2, 3, 0};
      req_valid = 4'd0; req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_mult_valid", {31'd0, mult_valid}, 32'd0);
      chk("rst_mult_clear", {31'd0, mult_clear}, 32'd0);
      chk("rst_product", {16'd0, rsp_product}, 32'd0);
      reset = 1'b0;

      // Contention: everyone requests, grants must rotate starting at 0.
      for (int i = 0; i < 4; i++) set_op(i, 8'(i * 17 + 3), 8'(8'hF0 + i));
      dut_grants.delete();
      req_valid = 4'hF;
      g = 0; n = 0;
      while (g < 5 && n < 400) begin
         cycle();
         for (int i = 0; i < 4; i++) begin
            if (acc_v[i]) begin
               g++;
               set_op(i, 8'($urandom), 8'($urandom));
            end
         end
         if (g >= 5) req_valid = 4'd0;
         n++;
      end
      req_valid = 4'd0;
      chk("contention_grants", g, 5);
      for (int i = 0; i < 5; i++)
         chk("grant_order", (i < dut_grants.size()) ? dut_grants[i] : -1, exp_ord[i]);
      wait_quiet();

      set_op(0, 8'd3, 8'd5);
      serve(4'b0001);
      wait_quiet();
      set_op(2, 8'hFC, 8'h07);
      serve(4'b0100);
      wait_quiet();

      // Backpressure: response held, a pending requester must not be granted.
      rsp_ready = 1'b0;
      set_op(1, 8'h81, 8'h7F);
      set_op(3, 8'h22, 8'hE5);
      serve(4'b0010);
      n = 0;
      while (!rsp_valid && n < 100) begin cycle(); n++; end
      chk("bp_rsp_seen", {31'd0, rsp_valid}, 32'd1);
      req_valid[3] = 1'b1;
      repeat (10) cycle();
      rsp_ready = 1'b1;
      serve(4'b1000);
      wait_quiet();

      // Stale done while idle: clear first, then grant.
      inject_stale = 1'b1;
      cycle();
      inject_stale = 1'b0;
      set_op(0, 8'h80, 8'h80);
      serve(4'b0001);
      wait_quiet();

      // Async reset in BUSY drops the job and reinitialises the pointer.
      set_op(2, 8'h11, 8'h22);
      rc = resp_cnt;
      serve(4'b0100);
      #2 reset = 1'b1;
      #1;
      chk("ar_mult_valid", {31'd0, mult_valid}, 32'd0);
      chk("ar_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("ar_req_ready", {28'd0, req_ready}, 32'd0);
      chk("ar_mult_m", {24'd0, mult_m}, 32'd0);
      chk("ar_rsp_id", {30'd0, rsp_id}, 32'd0);
      repeat (2) cycle();
      reset = 1'b0;
      repeat (5) cycle();
      chk("ar_no_response", resp_cnt, rc);
      set_op(1, 8'h05, 8'hFB);
      set_op(3, 8'h7F, 8'h7F);
      dut_grants.delete();
      serve(4'b1010);
      wait_quiet();
      chk("ar_first_grant", (dut_grants.size() > 0) ? dut_grants[0] : -1, 1);
      chk("ar_second_grant", (dut_grants.size() > 1) ? dut_grants[1] : -1, 3);

`ifdef MULT_SHARE_TIMEOUT_EN
      hang = 1'b1;
      set_op(2, 8'h33, 8'h44);
      serve(4'b0100);
      n = 0; g = 0;
      while (!rsp_valid && n < 200) begin
         if (mult_valid) g++;
         cycle();
         n++;
      end
      chk("tmo_busy_cycles", g, 64);
      wait_quiet();
      hang = 1'b0;
`endif

      // Randomised traffic with random response backpressure.
      for (int c = 0; c < 800; c++) begin
         cycle();
         rsp_ready = ($urandom % 4) != 0;
         for (int i = 0; i < 4; i++) begin
            if (acc_v[i]) begin
               set_op(i, 8'($urandom), 8'($urandom));
               req_valid[i] = 1'($urandom % 2);
            end else if (!req_valid[i]) begin
               req_valid[i] = ($urandom % 4) == 0;
            end else if (($urandom % 16) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
      end
      req_valid = 4'd0;
      rsp_ready = 1'b1;
      wait_quiet();
      chk("scoreboard_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
